// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: requester count,
// FSM state encodings and index <-> one-hot helpers.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-priority picker: returns the first requester found when
// scanning from ptr upward, wrapping past the last index back to 0.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Walk the scan order backwards so the nearest requester to ptr is written last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx_o = ptr_i;
        any_o = 1'b0;
        cand  = ptr_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_robin_mux_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 single-bit
// mux. Grants one requester at a time, limits each tenure to MAX_HOLD cycles
// while others wait, and presents the owner's data bit qualified by out_valid.
// Optional macro MUX_SETTLE_EN inserts one SETTLE cycle after every new grant
// so the mux has a full cycle to settle before out_valid rises.
module round_robin_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] grant,
    output logic       address0,
    output logic       address1,
    output logic       out,
    output logic       out_valid
);

`ifdef MUX_SETTLE_EN
    localparam state_t NEW_GRANT = SETTLE;
`else
    localparam state_t NEW_GRANT = GRANT;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0]   arb_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] data_vec;
    logic               owner_req;
    logic               others_req;
    logic               at_limit;
    logic               rel;

    assign owner_oh   = idx_to_onehot(owner_q);
    assign owner_req  = |(req & owner_oh);
    assign others_req = |(req & ~owner_oh);
    assign at_limit   = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    assign rel        = !owner_req || (at_limit && others_req);

    // On a release the pointer moves past the owner before re-picking, which
    // puts the owner last in the scan and so excludes it while others wait.
    assign arb_ptr = (state_q == GRANT) ? owner_q + IDX_W'(1) : ptr_q;

    rr_pick u_pick (
        .req_i (req),
        .ptr_i (arb_ptr),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Next-state logic: arbitration, tenure limit and back-to-back handover.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = NEW_GRANT;
                end
            end
            SETTLE: begin
                hold_cnt_d = '0;
                state_d    = GRANT;
            end
            GRANT: begin
                if (rel) begin
                    ptr_d      = owner_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    if (others_req) begin
                        owner_d = pick_idx;
                        state_d = NEW_GRANT;
                    end else begin
                        owner_d = '0;
                        state_d = IDLE;
                    end
                end else if (at_limit) begin
                    // Sole requester at the limit keeps the channel; only the tenure restarts.
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                owner_d    = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State, owner, pointer and tenure registers; reset takes effect without a clock.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Outputs decode straight from registers, so the mux select never glitches.
    assign data_vec              = {in3, in2, in1, in0};
    assign grant                 = (state_q == IDLE) ? '0 : owner_oh;
    assign {address1, address0}  = (state_q == IDLE) ? '0 : owner_q;
    assign out_valid             = (state_q == GRANT);
    assign out                   = out_valid & data_vec[owner_q];

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Self-checking bench for round_robin_mux_arbiter. A behavioural model tracks
// owner / pointer / tenure as plain integers and predicts every output each cycle.
// Follows MUX_SETTLE_EN the same way as the design.
module tb_round_robin_mux_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 2;
`ifdef MUX_SETTLE_EN
    localparam int SETTLE_ON = 1;
`else
    localparam int SETTLE_ON = 0;
`endif
    // Cycles one owner keeps the channel under full contention.
    localparam int PERIOD = MAX_HOLD + SETTLE_ON;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       in0, in1, in2, in3;
    logic [3:0] grant;
    logic       address0, address1, out, out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner -1 means idle.
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_settle;

    always #5 clk = ~clk;

    round_robin_mux_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .grant     (grant),
        .address0  (address0),
        .address1  (address1),
        .out       (out),
        .out_valid (out_valid)
    );

    function automatic int rr_first(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_cnt    = 0;
        m_settle = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int  nxt;
        bit  others;
        if (m_owner < 0) begin
            nxt = rr_first(r, m_ptr);
            if (nxt >= 0) begin
                m_owner  = nxt;
                m_cnt    = 0;
                m_settle = SETTLE_ON;
            end
        end else if (m_settle != 0) begin
            m_settle = 0;
        end else begin
            others = (r & ~(4'(1) << m_owner)) != 4'd0;
            if (!r[m_owner] || (m_cnt == MAX_HOLD - 1 && others)) begin
                m_ptr = (m_owner + 1) % 4;
                m_cnt = 0;
                if (others) begin
                    m_owner  = rr_first(r, m_ptr);
                    m_settle = SETTLE_ON;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_cnt = (m_cnt + 1) % MAX_HOLD;
            end
        end
    endtask

    // Packed {grant, address1, address0, out_valid, out} predicted by the model.
    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        logic [1:0] a;
        logic       v;
        logic       o;
        logic [3:0] din;
        din = {in3, in2, in1, in0};
        g = '0; a = '0; v = 1'b0; o = 1'b0;
        if (m_owner >= 0) begin
            g = 4'(1) << m_owner;
            a = 2'(m_owner);
            v = (m_settle == 0);
            o = v & din[m_owner];
        end
        return {g, a, v, o};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {grant, address1, address0, out_valid, out};
    endfunction

    // Drive one cycle of stimulus, let the edge happen, stop at the falling edge.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        req = r;
        {in3, in2, in1, in0} = d;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        if (obs_vec() !== 8'h00) begin
            n_bad++; $display("FAIL reset_init: got %b want %b", obs_vec(), 8'h00);
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 4'($urandom));
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL reset_pre cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
        end
        // Mid-cycle assertion with no clock edge in between.
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        if (obs_vec() !== 8'h00) begin
            n_bad++; $display("FAIL reset_async: got %b want %b", obs_vec(), 8'h00);
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        step(4'b0010, 4'b0010);
        if ({grant, address1, address0} !== 6'b0010_01) begin
            n_bad++; $display("FAIL single_grant: got %b want %b", {grant, address1, address0}, 6'b0010_01);
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 4'b0010);
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL single cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
        end
        step(4'b0000, 4'b0010);
        if (obs_vec() !== 8'h00) begin
            n_bad++; $display("FAIL single_idle: got %b want %b", obs_vec(), 8'h00);
        end
        n_cmp++;
    endtask

    task automatic test_contention();
        int exp_owner;
        apply_reset();
        for (int k = 0; k < 5 * PERIOD; k++) begin
            step(4'b1111, 4'($urandom));
            exp_owner = (k / PERIOD) % 4;
            if (grant !== 4'(1) << exp_owner) begin
                n_bad++; $display("FAIL contention_owner k%0d: got %b want %b", k, grant, 4'(1) << exp_owner);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL contention k%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] want;
        apply_reset();
        // Serve requester 2 briefly so the pointer lands on 3.
        step(4'b0100, 4'($urandom));
        step(4'b0000, 4'($urandom));
        step(4'b0000, 4'($urandom));
        for (int k = 0; k < 2 * PERIOD; k++) begin
            step(4'b0101, 4'($urandom));
            want = (k < PERIOD) ? 4'b0001 : 4'b0100;
            if (grant !== want) begin
                n_bad++; $display("FAIL wrap_owner k%0d: got %b want %b", k, grant, want);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL wrap k%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_sole_holder();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            step(4'b1000, 4'($urandom));
            if (grant !== 4'b1000) begin
                n_bad++; $display("FAIL sole_grant k%0d: got %b want %b", k, grant, 4'b1000);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL sole k%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    // Owner drops on the same edge a new request rises, then random handovers.
    task automatic test_back_to_back();
        logic [3:0] r;
        apply_reset();
        step(4'b0001, 4'($urandom));
        step(4'b0001, 4'($urandom));
        step(4'b0010, 4'($urandom));
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL handover: got %b want %b", obs_vec(), exp_vec());
        end
        n_cmp++;
        r = 4'($urandom);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            step(r, 4'($urandom));
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL random k%0d req %b: got %b want %b", k, r, obs_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

`ifdef MUX_SETTLE_EN
    task automatic test_settle();
        logic [2:0] want;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step(4'b0011, 4'($urandom));
            want = (k == 0) ? 3'b00_0 : (k == 5) ? 3'b01_0 : 3'b00_1;
            if ({address1, address0, out_valid} !== want) begin
                n_bad++; $display("FAIL settle k%0d: got %b want %b", k, {address1, address0, out_valid}, want);
            end
            n_cmp++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = '0;
        {in3, in2, in1, in0} = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap_skip();
        test_sole_holder();
        test_back_to_back();
`ifdef MUX_SETTLE_EN
        test_settle();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
